mem_arbiter: RTL and testbench

- Shares the single byte-wide synchronous memory port between the RV32I core and the host/memory manager (program loader, debug read-back).
- Stops the core cleanly through its run/cede handshake before handing over the port.
- While the host owns the port, sequences each host 32-bit word access as four little-endian byte beats.
- Sits between core, host and the memory macro.

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide memory port between the RV32I core and the host.
// Host word accesses are split into four little-endian byte beats.
module mem_arbiter #(
    parameter int MABL = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            core_run,
    input  logic            core_cede,
    input  logic            core_we,
    input  logic [7:0]      core_wd,
    input  logic [MABL-1:0] core_ad,
    input  logic            host_req,
    output logic            host_grant,
    input  logic            host_valid,
    input  logic            host_wr,
    input  logic [MABL-1:0] host_ad,
    input  logic [31:0]     host_wdata,
    output logic            host_ready,
    output logic            host_done,
    output logic [31:0]     host_rdata,
    input  logic [7:0]      mem_rd,
    output logic            mem_we,
    output logic [7:0]      mem_wd,
    output logic [MABL-1:0] mem_ad
);

    typedef enum logic [2:0] {
        S_CORE,
        S_DRAIN,
        S_HOST_IDLE,
        S_XFER,
        S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      beat_q, beat_d;
    logic            done_q, done_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            wr_q, wr_d;
    logic [MABL-1:0] ad_q, ad_d;
    logic [MABL-1:0] hold_ad_q, hold_ad_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [23:0]     rbuf_q, rbuf_d;

    logic [1:0]      beat_lo;
    logic [MABL-1:0] xfer_ad;
    logic            mem_we_raw;
    logic            host_ad_unused;

    assign host_ad_unused = ^host_ad[1:0];

    // The extra read-capture beat (4) keeps presenting the last byte address.
    assign beat_lo = beat_q[2] ? 2'd3 : beat_q[1:0];
    assign xfer_ad = ad_q + MABL'(beat_lo);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_CORE;
            beat_q  <= 3'd0;
            done_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        wr_q      <= wr_d;
        ad_q      <= ad_d;
        hold_ad_q <= hold_ad_d;
        wdata_q   <= wdata_d;
        rbuf_q    <= rbuf_d;
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        wr_d      = wr_q;
        ad_d      = ad_q;
        hold_ad_d = hold_ad_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;
        case (state_q)
            S_CORE: begin
                if (host_req) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (core_cede)      state_d = S_HOST_IDLE;
                else if (!host_req) state_d = S_CORE;
            end
            S_HOST_IDLE: begin
                if (host_valid) begin
                    wr_d    = host_wr;
                    ad_d    = {host_ad[MABL-1:2], 2'b00};
                    wdata_d = host_wdata;
                    beat_d  = 3'd0;
                    state_d = S_XFER;
                end else if (!host_req) begin
                    state_d = S_RELEASE;
                end
            end
            S_XFER: begin
                hold_ad_d = xfer_ad;
                beat_d    = beat_q + 3'd1;
                if (wr_q) begin
                    if (beat_q == 3'd3) begin
                        done_d  = 1'b1;
                        state_d = S_HOST_IDLE;
                    end
                end else begin
                    // mem_rd belongs to the address presented one beat earlier.
                    case (beat_q)
                        3'd1: rbuf_d[7:0]   = mem_rd;
                        3'd2: rbuf_d[15:8]  = mem_rd;
                        3'd3: rbuf_d[23:16] = mem_rd;
                        3'd4: begin
                            rdata_d = {mem_rd, rbuf_q};
                            done_d  = 1'b1;
                            state_d = S_HOST_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            S_RELEASE: begin
                state_d = S_CORE;
            end
            default: state_d = S_CORE;
        endcase
    end

    always_comb begin
        core_run   = 1'b0;
        host_grant = 1'b0;
        host_ready = 1'b0;
        mem_we_raw = 1'b0;
        mem_wd     = core_wd;
        mem_ad     = core_ad;
        case (state_q)
            S_CORE: begin
                core_run   = 1'b1;
                mem_we_raw = core_we;
            end
            S_DRAIN: begin
                mem_we_raw = core_we;
            end
            S_HOST_IDLE: begin
                host_grant = 1'b1;
                host_ready = 1'b1;
                mem_wd     = 8'd0;
                mem_ad     = hold_ad_q;
            end
            S_XFER: begin
                host_grant = 1'b1;
                mem_we_raw = wr_q && !beat_q[2];
                mem_wd     = wdata_q[{beat_lo, 3'b000} +: 8];
                mem_ad     = xfer_ad;
            end
            default: ;
        endcase
    end

    assign mem_we     = mem_we_raw & rst_n;
    assign host_done  = done_q;
    assign host_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed handover/transfer scenarios, then random
// traffic checked every cycle against a word-level reference model.
module tb_mem_arbiter;
    localparam int MABL = 19;
    localparam int MSZ  = 1 << MABL;
    localparam logic [2:0] P_CORE = 3'd0, P_DRAIN = 3'd1, P_HIDLE = 3'd2,
                           P_XFER = 3'd3, P_REL = 3'd4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            core_run, core_cede, core_we;
    logic [7:0]      core_wd;
    logic [MABL-1:0] core_ad;
    logic            host_req, host_grant, host_valid, host_wr;
    logic [MABL-1:0] host_ad;
    logic [31:0]     host_wdata;
    logic            host_ready, host_done;
    logic [31:0]     host_rdata;
    logic [7:0]      mem_rd;
    logic            mem_we;
    logic [7:0]      mem_wd;
    logic [MABL-1:0] mem_ad;

    mem_arbiter #(.MABL(MABL)) dut (
        .clk(clk), .rst_n(rst_n), .core_run(core_run), .core_cede(core_cede),
        .core_we(core_we), .core_wd(core_wd), .core_ad(core_ad),
        .host_req(host_req), .host_grant(host_grant), .host_valid(host_valid),
        .host_wr(host_wr), .host_ad(host_ad), .host_wdata(host_wdata),
        .host_ready(host_ready), .host_done(host_done), .host_rdata(host_rdata),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_wd(mem_wd), .mem_ad(mem_ad)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Environment memory (driven by DUT) and reference memory (driven by model).
    logic [7:0] env_mem [MSZ];
    logic [7:0] ref_mem [MSZ];
    bit         mem_init = 1'b0;

    // Reference model state: port owner phase, cycles into the current word.
    logic [2:0]      ph      = P_CORE;
    logic [2:0]      cyc     = 3'd0;
    logic            m_wr    = 1'b0;
    logic [MABL-1:0] m_ad    = '0;
    logic [31:0]     m_wdata = 32'd0;
    logic            m_done  = 1'b0;
    logic [31:0]     m_rdata = 32'd0;

    task automatic calc_exp(output logic e_we, output logic [MABL-1:0] e_ad,
                            output logic [7:0] e_wd, output logic e_adc, output logic e_wdc);
        e_we = 1'b0; e_ad = '0; e_wd = 8'd0; e_adc = 1'b0; e_wdc = 1'b0;
        if (ph == P_CORE || ph == P_DRAIN || ph == P_REL) begin
            e_we  = (ph != P_REL) ? core_we : 1'b0;
            e_ad  = core_ad;
            e_wd  = core_wd;
            e_adc = 1'b1;
            e_wdc = 1'b1;
        end else if (ph == P_XFER && cyc <= 3'd3) begin
            e_ad  = m_ad + MABL'(cyc);
            e_adc = 1'b1;
            if (m_wr) begin
                e_we  = 1'b1;
                e_wd  = 8'(m_wdata >> (8 * int'(cyc)));
                e_wdc = 1'b1;
            end
        end
        if (!rst_n) e_we = 1'b0;
    endtask

    always @(posedge clk) begin
        logic            e_we, e_adc, e_wdc;
        logic [MABL-1:0] e_ad;
        logic [7:0]      e_wd;
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                env_mem[i] = 8'($urandom);
                ref_mem[i] = env_mem[i];
            end
            for (int i = MSZ - 16; i < MSZ; i++) begin
                env_mem[i] = 8'($urandom);
                ref_mem[i] = env_mem[i];
            end
            env_mem[32'h202] = 8'h11; ref_mem[32'h202] = 8'h11;
            env_mem[32'h203] = 8'h22; ref_mem[32'h203] = 8'h22;
            mem_init = 1'b1;
        end
        mem_rd <= env_mem[mem_ad];
        if (mem_we) env_mem[mem_ad] = mem_wd;

        calc_exp(e_we, e_ad, e_wd, e_adc, e_wdc);
        if (e_we) ref_mem[e_ad] = e_wd;
        m_done = 1'b0;
        if (!rst_n) begin
            ph = P_CORE; cyc = 3'd0; m_rdata = 32'd0;
        end else begin
            case (ph)
                P_CORE:  if (host_req) ph = P_DRAIN;
                P_DRAIN: if (core_cede) ph = P_HIDLE; else if (!host_req) ph = P_CORE;
                P_HIDLE: begin
                    if (host_valid) begin
                        m_wr = host_wr; m_ad = host_ad & ~MABL'(3);
                        m_wdata = host_wdata; cyc = 3'd0; ph = P_XFER;
                    end else if (!host_req) ph = P_REL;
                end
                P_XFER: begin
                    // Write: 4 beats. Read: 4 address beats + 1 capture cycle.
                    if (m_wr ? (cyc == 3'd3) : (cyc == 3'd4)) begin
                        if (!m_wr)
                            m_rdata = {ref_mem[m_ad + MABL'(3)], ref_mem[m_ad + MABL'(2)],
                                       ref_mem[m_ad + MABL'(1)], ref_mem[m_ad]};
                        m_done = 1'b1;
                        ph = P_HIDLE;
                    end else cyc = cyc + 3'd1;
                end
                default: ph = P_CORE;
            endcase
        end
    end

    always @(negedge clk) begin
        logic            e_we, e_adc, e_wdc;
        logic [MABL-1:0] e_ad;
        logic [7:0]      e_wd;
        if (cmp_en) begin
            calc_exp(e_we, e_ad, e_wd, e_adc, e_wdc);
            chk("m_core_run", 32'(core_run), 32'(ph == P_CORE));
            chk("m_host_grant", 32'(host_grant), 32'(ph == P_HIDLE || ph == P_XFER));
            chk("m_host_ready", 32'(host_ready), 32'(ph == P_HIDLE));
            chk("m_host_done", 32'(host_done), 32'(m_done));
            chk("m_host_rdata", host_rdata, m_rdata);
            chk("m_mem_we", 32'(mem_we), 32'(e_we));
            if (e_adc) chk("m_mem_ad", 32'(mem_ad), 32'(e_ad));
            if (e_wdc) chk("m_mem_wd", 32'(mem_wd), 32'(e_wd));
            chk("m_grant_run_excl", 32'(host_grant & core_run), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        return 8'(w >> (8 * k));
    endfunction

    int lat;
    int rnd_done;

    initial begin
        rst_n = 1'b0; core_cede = 1'b0; core_we = 1'b1; core_wd = 8'h00; core_ad = '0;
        host_req = 1'b0; host_valid = 1'b0; host_wr = 1'b0; host_ad = '0; host_wdata = 32'd0;
        tick();
        cmp_en = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_core_run", 32'(core_run), 32'd1);
        chk("rst_host_grant", 32'(host_grant), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_host_done", 32'(host_done), 32'd0);
        chk("rst_host_rdata", host_rdata, 32'd0);
        chk("rst_mem_we_forced", 32'(mem_we), 32'd0);

        tick();
        rst_n = 1'b1; core_we = 1'b1; core_ad = MABL'(32'h10); core_wd = 8'hA5;
        @(negedge clk);
        chk("core_mem_we", 32'(mem_we), 32'd1);
        chk("core_mem_ad", 32'(mem_ad), 32'h10);
        chk("core_mem_wd", 32'(mem_wd), 32'hA5);
        chk("core_run_idle", 32'(core_run), 32'd1);
        chk("core_grant_idle", 32'(host_grant), 32'd0);

        // Handover: cede withheld for 5 DRAIN cycles.
        tick();
        core_we = 1'b0; host_req = 1'b1; core_cede = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            core_we = 1'b1; core_ad = MABL'(32'h20 + i); core_wd = 8'(8'h30 + i);
            @(negedge clk);
            chk("drain_core_run", 32'(core_run), 32'd0);
            chk("drain_grant", 32'(host_grant), 32'd0);
            chk("drain_mem_ad", 32'(mem_ad), 32'h20 + 32'(i));
            chk("drain_mem_we", 32'(mem_we), 32'd1);
        end
        tick();
        core_cede = 1'b1;
        @(negedge clk);
        chk("cede_grant_not_yet", 32'(host_grant), 32'd0);
        tick();
        @(negedge clk);
        chk("grant_after_cede", 32'(host_grant), 32'd1);
        chk("grant_ready", 32'(host_ready), 32'd1);
        chk("grant_mem_we_blocked", 32'(mem_we), 32'd0);
        tick();
        core_we = 1'b0; core_cede = 1'b0;

        // Host write of 0xDEADBEEF, unaligned address 0x103 -> word 0x100.
        host_valid = 1'b1; host_wr = 1'b1; host_ad = MABL'(32'h103); host_wdata = 32'hDEADBEEF;
        tick();
        host_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                chk("wr_beat_we", 32'(mem_we), 32'd1);
                chk("wr_beat_ad", 32'(mem_ad), 32'h100 + 32'(k - 1));
                chk("wr_beat_wd", 32'(mem_wd), 32'(byte_of(32'hDEADBEEF, k - 1)));
                chk("wr_busy_ready", 32'(host_ready), 32'd0);
            end
            if (host_done && lat == 0) lat = k;
            tick();
        end
        chk("wr_done_latency", 32'(lat), 32'd5);
        chk("wr_mem_b0", 32'(env_mem[32'h100]), 32'hEF);
        chk("wr_mem_b3", 32'(env_mem[32'h103]), 32'hDE);

        // Read back with host_valid held during the transfer (ignored).
        host_valid = 1'b1; host_wr = 1'b0; host_ad = MABL'(32'h100);
        tick();
        host_wr = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k <= 5) begin
                chk("rd_busy_ready", 32'(host_ready), 32'd0);
                chk("rd_mem_we", 32'(mem_we), 32'd0);
            end
            if (k <= 4) chk("rd_beat_ad", 32'(mem_ad), 32'h100 + 32'(k - 1));
            if (k == 6) chk("rd_rdata", host_rdata, 32'hDEADBEEF);
            if (host_done && lat == 0) lat = k;
            if (k == 5) host_valid = 1'b0;
            tick();
        end
        chk("rd_done_latency", 32'(lat), 32'd6);

        // Read with host_req dropped mid-transfer, then release.
        host_valid = 1'b1; host_wr = 1'b0; host_ad = MABL'(32'h102);
        tick();
        host_valid = 1'b0; core_we = 1'b1; core_ad = MABL'(32'h55); core_wd = 8'h66;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) host_req = 1'b0;
            if (k == 6) begin
                chk("drop_rd_done", 32'(host_done), 32'd1);
                chk("drop_rd_rdata", host_rdata, 32'hDEADBEEF);
            end
            tick();
        end
        @(negedge clk);
        chk("rel_grant", 32'(host_grant), 32'd0);
        chk("rel_mem_we", 32'(mem_we), 32'd0);
        chk("rel_core_run", 32'(core_run), 32'd0);
        chk("rel_mem_ad", 32'(mem_ad), 32'h55);
        tick();
        @(negedge clk);
        chk("after_rel_run", 32'(core_run), 32'd1);
        chk("after_rel_mem_we", 32'(mem_we), 32'd1);
        tick();
        core_we = 1'b0;

        // Reset asserted during write beat 2.
        host_req = 1'b1; core_cede = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("re_grant", 32'(host_grant), 32'd1);
        tick();
        core_cede = 1'b0;
        host_valid = 1'b1; host_wr = 1'b1; host_ad = MABL'(32'h200); host_wdata = 32'hCAFEF00D;
        tick();
        host_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_beat2_mem_we", 32'(mem_we), 32'd0);
        tick();
        rst_n = 1'b1; host_req = 1'b0;
        @(negedge clk);
        chk("post_rst_run", 32'(core_run), 32'd1);
        chk("post_rst_grant", 32'(host_grant), 32'd0);
        chk("post_rst_rdata", host_rdata, 32'd0);
        tick(); tick();
        chk("abort_b0", 32'(env_mem[32'h200]), 32'h0D);
        chk("abort_b1", 32'(env_mem[32'h201]), 32'hF0);
        chk("abort_b2_kept", 32'(env_mem[32'h202]), 32'h11);
        chk("abort_b3_kept", 32'(env_mem[32'h203]), 32'h22);

        // Random traffic against the model.
        rnd_done = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst_n      = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 15) == 0) host_req = ~host_req;
            core_cede  = ($urandom_range(0, 3) == 0);
            core_we    = 1'($urandom_range(0, 1));
            core_ad    = MABL'($urandom_range(0, 1023));
            core_wd    = 8'($urandom);
            host_valid = ($urandom_range(0, 2) == 0);
            host_wr    = 1'($urandom_range(0, 1));
            host_ad    = ($urandom_range(0, 9) == 0) ? MABL'(32'h7FFFC + $urandom_range(0, 3))
                                                     : MABL'($urandom_range(0, 1023));
            host_wdata = $urandom;
            if (host_done) rnd_done++;
        end
        chk("rand_activity", 32'(rnd_done > 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
